// File: rtl/stream_output_handler.sv
// Purpose : round-robin merge of two 41-bit result streams, packed three per 128-bit output word.
// Latency : the third result handshaken in cycle k shows so_valid in k+2; a lone partial word is flushed
//           FLUSH_TIMEOUT idle cycles later. Backpressure: full packer with a blocked output drops both rdy.
// Ports   : clk/rst (sync, active-high); result_{0,1}_{data,valid}_in / result_{0,1}_rdy_out input streams;
//           so_data/so_valid/so_rdy output stream; results_cnt_out/words_cnt_out wrapping statistics.
// Word    : [40:0]=slot0 [81:41]=slot1 [122:82]=slot2 [124:123]=valid slot count [127:125]=0.
module stream_output_handler #(
   parameter int FLUSH_TIMEOUT = 64,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [40:0]          result_0_data_in,
   input  logic                 result_0_valid_in,
   output logic                 result_0_rdy_out,
   input  logic [40:0]          result_1_data_in,
   input  logic                 result_1_valid_in,
   output logic                 result_1_rdy_out,
   output logic [127:0]         so_data,
   output logic                 so_valid,
   input  logic                 so_rdy,
   output logic [CNT_WIDTH-1:0] results_cnt_out,
   output logic [CNT_WIDTH-1:0] words_cnt_out
);

   localparam logic [15:0] TIMEOUT = 16'(FLUSH_TIMEOUT);

   logic [1:0]   cnt;
   logic [40:0]  slot0, slot1, slot2;
   logic [15:0]  timer;
   logic         last_grant;

   logic         out_free;
   logic         emit;
   logic         can_accept;
   logic         grant_0, grant_1;
   logic         accept;
   logic [40:0]  acc_data;
   logic [127:0] packed_word;

   assign out_free    = !so_valid || so_rdy;
   // A partial word is forced out once the idle timer has saturated, but only when the output can take it.
   assign emit        = ((cnt == 2'd3) || ((cnt != 2'd0) && (timer == TIMEOUT))) && out_free;
   // A full packer still accepts when it drains this same cycle: the new result refills slot0.
   assign can_accept  = (cnt != 2'd3) || emit;
   // Unused slots are always zero because the packer clears them on every drain and on reset.
   assign packed_word = {3'b000, cnt, slot2, slot1, slot0};

   always_comb begin
      grant_0 = 1'b0;
      grant_1 = 1'b0;
      if (result_0_valid_in && result_1_valid_in) begin
         // Tie: the buffer that did not win last time goes next.
         grant_0 = last_grant;
         grant_1 = !last_grant;
      end else begin
         grant_0 = result_0_valid_in;
         grant_1 = result_1_valid_in;
      end
   end

   assign result_0_rdy_out = grant_0 && can_accept && !rst;
   assign result_1_rdy_out = grant_1 && can_accept && !rst;
   // A grant implies the matching valid, so rdy alone marks the handshake.
   assign accept           = result_0_rdy_out || result_1_rdy_out;
   assign acc_data         = result_1_rdy_out ? result_1_data_in : result_0_data_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         so_data         <= '0;
         so_valid        <= 1'b0;
         cnt             <= 2'd0;
         slot0           <= '0;
         slot1           <= '0;
         slot2           <= '0;
         timer           <= '0;
         last_grant      <= 1'b1;
         results_cnt_out <= '0;
         words_cnt_out   <= '0;
      end else begin
         // Output register: load on emit, otherwise clear once the consumer has taken the word.
         if (emit) begin
            so_data  <= packed_word;
            so_valid <= 1'b1;
         end else if (out_free) begin
            so_valid <= 1'b0;
         end

         // Packer
         if (emit) begin
            slot1 <= '0;
            slot2 <= '0;
            if (accept) begin
               slot0 <= acc_data;
               cnt   <= 2'd1;
            end else begin
               slot0 <= '0;
               cnt   <= 2'd0;
            end
         end else if (accept) begin
            case (cnt)
               2'd0:    slot0 <= acc_data;
               2'd1:    slot1 <= acc_data;
               default: slot2 <= acc_data;
            endcase
            cnt <= cnt + 2'd1;
         end

         // Idle timer: runs only while a partial word waits with no activity.
         if (accept || emit || (cnt == 2'd0)) begin
            timer <= '0;
         end else if (timer != TIMEOUT) begin
            timer <= timer + 16'd1;
         end

         if (accept) begin
            last_grant      <= result_1_rdy_out;
            results_cnt_out <= results_cnt_out + CNT_WIDTH'(1);
         end

         if (so_valid && so_rdy) begin
            words_cnt_out <= words_cnt_out + CNT_WIDTH'(1);
         end
      end
   end

endmodule
